// File: rtl/hawk_axi_line_master.sv
// hawk_axi_line_master: single-outstanding 64B line master that
// turns core line requests into 2-beat AXI4 INCR bursts.
module hawk_axi_line_master #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ID_W           = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wr,
  input  logic [63:0]     req_addr,
  input  logic [ID_W-1:0] req_id,
  input  logic [511:0]    req_wdata,
  input  logic [63:0]     req_wstrb,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_wr,
  output logic [ID_W-1:0] rsp_id,
  output logic [511:0]    rsp_rdata,
  output logic            rsp_err,
  output logic [ID_W-1:0] axi_awid,
  output logic [63:0]     axi_awaddr,
  output logic [7:0]      axi_awlen,
  output logic [2:0]      axi_awsize,
  output logic [1:0]      axi_awburst,
  output logic            axi_awvalid,
  input  logic            axi_awready,
  output logic [255:0]    axi_wdata,
  output logic [31:0]     axi_wstrb,
  output logic            axi_wlast,
  output logic            axi_wvalid,
  input  logic            axi_wready,
  input  logic [ID_W-1:0] axi_bid,
  input  logic [1:0]      axi_bresp,
  input  logic            axi_bvalid,
  output logic            axi_bready,
  output logic [ID_W-1:0] axi_arid,
  output logic [63:0]     axi_araddr,
  output logic [7:0]      axi_arlen,
  output logic [2:0]      axi_arsize,
  output logic [1:0]      axi_arburst,
  output logic            axi_arvalid,
  input  logic            axi_arready,
  input  logic [ID_W-1:0] axi_rid,
  input  logic [255:0]    axi_rdata,
  input  logic [1:0]      axi_rresp,
  input  logic            axi_rlast,
  input  logic            axi_rvalid,
  output logic            axi_rready
);

  localparam int WD_W =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W0, S_W1, S_B, S_AR, S_R, S_RSP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_live;
  logic            r_wr;
  logic [63:0]     r_addr;
  logic [ID_W-1:0] r_id;
  logic [511:0]    r_wdata;
  logic [63:0]     r_wstrb;
  logic [511:0]    r_rdata;
  logic            r_err;
  logic            r_beat;
  logic [WD_W-1:0] r_wdog;
  logic            w_wait;
  logic            w_to;
  logic            w_acc;
  logic            w_b_hs;
  logic            w_r_hs;

  assign w_wait = (r_state == S_B) || (r_state == S_R);
  assign w_to   = w_wait &&
                  (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
  assign w_acc  = req_valid && req_ready;
  assign w_b_hs = axi_bvalid && axi_bready;
  assign w_r_hs = axi_rvalid && axi_rready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_acc) w_next = req_wr ? S_AW : S_AR;
      S_AW:   if (axi_awready) w_next = S_W0;
      S_W0:   if (axi_wready) w_next = S_W1;
      S_W1:   if (axi_wready) w_next = S_B;
      S_B:    if (w_to || axi_bvalid) w_next = S_RSP;
      S_AR:   if (axi_arready) w_next = S_R;
      S_R:    if (w_to || (axi_rvalid && r_beat)) w_next = S_RSP;
      S_RSP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Payload is gated by state so idle/reset outputs read as zero.
  always_comb begin
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_wr      = 1'b0;
    rsp_id      = '0;
    rsp_rdata   = '0;
    rsp_err     = 1'b0;
    axi_awid    = '0;
    axi_awaddr  = '0;
    axi_awlen   = '0;
    axi_awsize  = '0;
    axi_awburst = '0;
    axi_awvalid = 1'b0;
    axi_wdata   = '0;
    axi_wstrb   = '0;
    axi_wlast   = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    axi_arid    = '0;
    axi_araddr  = '0;
    axi_arlen   = '0;
    axi_arsize  = '0;
    axi_arburst = '0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    unique case (r_state)
      S_IDLE: req_ready = r_live;
      S_AW: begin
        axi_awvalid = 1'b1;
        axi_awid    = r_id;
        axi_awaddr  = r_addr;
        axi_awlen   = 8'd1;
        axi_awsize  = 3'd5;
        axi_awburst = 2'b01;
      end
      S_W0: begin
        axi_wvalid = 1'b1;
        axi_wdata  = r_wdata[255:0];
        axi_wstrb  = r_wstrb[31:0];
      end
      S_W1: begin
        axi_wvalid = 1'b1;
        axi_wdata  = r_wdata[511:256];
        axi_wstrb  = r_wstrb[63:32];
        axi_wlast  = 1'b1;
      end
      S_B: axi_bready = !w_to;
      S_AR: begin
        axi_arvalid = 1'b1;
        axi_arid    = r_id;
        axi_araddr  = r_addr;
        axi_arlen   = 8'd1;
        axi_arsize  = 3'd5;
        axi_arburst = 2'b01;
      end
      S_R: axi_rready = !w_to;
      S_RSP: begin
        rsp_valid = 1'b1;
        rsp_wr    = r_wr;
        rsp_id    = r_id;
        rsp_rdata = r_rdata;
        rsp_err   = r_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live  <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_id    <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_beat  <= 1'b0;
      r_wdog  <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_acc) begin
        r_wr    <= req_wr;
        r_addr  <= req_addr & ~64'h3f;
        r_id    <= req_id;
        r_wdata <= req_wdata;
        r_wstrb <= req_wstrb;
        r_rdata <= '0;
        r_err   <= 1'b0;
        r_beat  <= 1'b0;
      end
      if (w_wait) r_wdog <= r_wdog + 1'b1;
      else        r_wdog <= '0;
      if (w_to) r_err <= 1'b1;
      if (w_b_hs)
        r_err <= r_err | (axi_bresp != 2'b00) |
                 (axi_bid != r_id);
      // rlast must be low on beat0 and high on beat1
      if (w_r_hs) begin
        r_beat <= 1'b1;
        if (r_beat) r_rdata[511:256] <= axi_rdata;
        else        r_rdata[255:0]   <= axi_rdata;
        r_err <= r_err | (axi_rresp != 2'b00) |
                 (axi_rid != r_id) | (axi_rlast != r_beat);
      end
    end
  end

endmodule

// File: tb/tb_hawk_axi_line_master.sv
// tb_hawk_axi_line_master: random line traffic against a line-level
// memory model, with fault injection, timeouts and mid-burst resets.
module tb_hawk_axi_line_master;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_wr;
  logic [63:0]  req_addr;
  logic [5:0]   req_id;
  logic [511:0] req_wdata;
  logic [63:0]  req_wstrb;
  logic         rsp_valid, rsp_ready, rsp_wr, rsp_err;
  logic [5:0]   rsp_id;
  logic [511:0] rsp_rdata;
  logic [5:0]   axi_awid, axi_arid, axi_bid, axi_rid;
  logic [63:0]  axi_awaddr, axi_araddr;
  logic [7:0]   axi_awlen, axi_arlen;
  logic [2:0]   axi_awsize, axi_arsize;
  logic [1:0]   axi_awburst, axi_arburst, axi_bresp, axi_rresp;
  logic         axi_awvalid, axi_awready, axi_arvalid, axi_arready;
  logic [255:0] axi_wdata, axi_rdata;
  logic [31:0]  axi_wstrb;
  logic         axi_wlast, axi_wvalid, axi_wready;
  logic         axi_bvalid, axi_bready;
  logic         axi_rlast, axi_rvalid, axi_rready;

  always #5 clk = ~clk;

  hawk_axi_line_master #(.TIMEOUT_CYCLES(TO), .ID_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_id(req_id),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_wr(rsp_wr), .rsp_id(rsp_id),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  int checks = 0;
  int errors = 0;

  logic [511:0] slv_mem [logic [63:0]];
  logic [511:0] ref_mem [logic [63:0]];

  bit           act = 0;
  bit           in_flight = 0;
  bit           e_wr;
  logic [63:0]  e_addr;
  logic [5:0]   e_id;
  logic [511:0] e_wdata;
  logic [63:0]  e_wstrb;
  logic [511:0] e_rdata;
  bit           e_err;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;

  task automatic chk(input string nm, input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [511:0] merge(input logic [511:0] old,
      input logic [511:0] d, input logic [63:0] s);
    logic [511:0] r;
    r = old;
    for (int b = 0; b < 64; b++)
      if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [511:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 512'd0;
  endfunction

  function automatic logic [511:0] slv_rd(input logic [63:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : 512'd0;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Protocol-level compare against the transaction being run.
  always @(negedge clk) begin
    if (act && rst_n) begin
      if (in_flight) chk("req_ready_busy", 512'(req_ready), 512'd0);
      if (axi_awvalid) begin
        chk("aw_is_write", 512'(e_wr), 512'd1);
        chk("aw_once", 512'(aw_cnt), 512'd0);
        chk("awaddr", 512'(axi_awaddr), 512'({e_addr[63:6], 6'd0}));
        chk("awlen", 512'(axi_awlen), 512'd1);
        chk("awsize", 512'(axi_awsize), 512'd5);
        chk("awburst", 512'(axi_awburst), 512'd1);
        chk("awid", 512'(axi_awid), 512'(e_id));
      end
      if (axi_wvalid) begin
        chk("w_after_aw", 512'(aw_cnt), 512'd1);
        chk("w_count", 512'(w_cnt < 2), 512'd1);
        chk("wdata", 512'(axi_wdata),
            512'(w_cnt == 1 ? e_wdata[511:256] : e_wdata[255:0]));
        chk("wstrb", 512'(axi_wstrb),
            512'(w_cnt == 1 ? e_wstrb[63:32] : e_wstrb[31:0]));
        chk("wlast", 512'(axi_wlast), 512'(w_cnt == 1));
      end
      if (axi_arvalid) begin
        chk("ar_is_read", 512'(e_wr), 512'd0);
        chk("ar_once", 512'(ar_cnt), 512'd0);
        chk("araddr", 512'(axi_araddr), 512'({e_addr[63:6], 6'd0}));
        chk("arlen", 512'(axi_arlen), 512'd1);
        chk("arsize", 512'(axi_arsize), 512'd5);
        chk("arburst", 512'(axi_arburst), 512'd1);
        chk("arid", 512'(axi_arid), 512'(e_id));
      end
      if (axi_bready)
        chk("bready_scope",
            512'(e_wr && w_cnt == 2 && b_cnt == 0), 512'd1);
      if (axi_rready)
        chk("rready_scope",
            512'(!e_wr && ar_cnt == 1 && r_cnt < 2), 512'd1);
      if (rsp_valid) begin
        chk("rsp_wr", 512'(rsp_wr), 512'(e_wr));
        chk("rsp_id", 512'(rsp_id), 512'(e_id));
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_err", 512'(rsp_err), 512'(e_err));
      end
    end
  end

  task automatic clear_inputs();
    req_valid = 0; req_wr = 0; req_addr = '0; req_id = '0;
    req_wdata = '0; req_wstrb = '0; rsp_ready = 0;
    axi_awready = 0; axi_wready = 0; axi_arready = 0;
    axi_bvalid = 0; axi_bid = '0; axi_bresp = '0;
    axi_rvalid = 0; axi_rid = '0; axi_rdata = '0;
    axi_rresp = '0; axi_rlast = 0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, 512'({req_ready, rsp_valid, rsp_wr, rsp_err,
        axi_awvalid, axi_wvalid, axi_wlast, axi_bready,
        axi_arvalid, axi_rready}), 512'd0);
    chk({nm, "_ax"}, 512'({axi_awid, axi_awaddr, axi_awlen,
        axi_awsize, axi_awburst, axi_arid, axi_araddr, axi_arlen,
        axi_arsize, axi_arburst, axi_wstrb, rsp_id}), 512'd0);
    chk({nm, "_wdata"}, 512'(axi_wdata), 512'd0);
    chk({nm, "_rdata"}, rsp_rdata, 512'd0);
  endtask

  // fault: 0 none, 1 bresp, 2 rid on beat1, 3 rlast on beat0,
  // 4 no B, 5 only one R beat, 6 bid, 7 rresp on beat0.
  // abort: 1 reset in W1, 2 reset between R beats.
  task automatic run_txn(input bit wr, input logic [63:0] addr,
      input logic [5:0] id, input logic [511:0] wd,
      input logic [63:0] ws, input bit stall, input int rgap,
      input int fault, input int abort,
      output int lat, output int blat);
    logic [63:0]  la;
    logic [255:0] cur_wd;
    logic [31:0]  cur_ws;
    bit hs_req, hs_aw, hs_w, hs_b, hs_ar, hs_r, hs_rsp, done;
    bit b_pend;
    int b_wait, r_left, r_gap, acc_k, b_k, k;
    la = {addr[63:6], 6'd0};
    e_wr = wr; e_addr = addr; e_id = id;
    e_wdata = wd; e_wstrb = ws;
    e_err = (fault != 0);
    if (wr) e_rdata = '0;
    else begin
      e_rdata = ref_rd(la);
      if (fault == 5) e_rdata[511:256] = '0;
    end
    if (wr && abort == 0) ref_mem[la] = merge(ref_rd(la), wd, ws);
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    hs_req = 0; hs_aw = 0; hs_w = 0; hs_b = 0;
    hs_ar = 0; hs_r = 0; hs_rsp = 0; done = 0;
    b_pend = 0; b_wait = 0; r_left = 0; r_gap = 0;
    acc_k = -1; b_k = -1; lat = -1; blat = -1;
    cur_wd = '0; cur_ws = '0;
    act = 1;
    req_valid = 1; req_wr = wr; req_addr = addr; req_id = id;
    req_wdata = wd; req_wstrb = ws;
    k = 0;
    while (!done && k < 300) begin
      if (hs_req) begin
        req_valid = 0; req_wdata = rnd512(); req_addr = '1;
        acc_k = k; in_flight = 1;
      end
      if (hs_aw) aw_cnt++;
      if (hs_w) begin
        slv_mem[la] = merge(slv_rd(la), {cur_wd, cur_wd},
            w_cnt == 1 ? {cur_ws, 32'd0} : {32'd0, cur_ws});
        w_cnt++;
        if (w_cnt == 2) begin
          b_pend = 1; b_k = k;
          b_wait = stall ? $urandom_range(0, 4) : 0;
        end
      end
      if (hs_b) begin b_cnt++; axi_bvalid = 0; end
      if (hs_ar) begin
        ar_cnt++;
        r_left = (fault == 5) ? 1 : 2;
        r_gap = stall ? $urandom_range(0, 2) : 0;
      end
      if (hs_r) begin
        r_cnt++; axi_rvalid = 0;
        r_gap = (rgap >= 0) ? rgap :
                stall ? $urandom_range(0, 3) : 0;
      end
      if (hs_rsp) begin done = 1; in_flight = 0; break; end
      if (rsp_valid && lat < 0) begin
        lat = k - acc_k + 1;
        if (b_k >= 0) blat = k - b_k;
      end
      if ((abort == 1 && axi_wvalid && axi_wlast) ||
          (abort == 2 && r_cnt == 1 && axi_rready)) begin
        act = 0; in_flight = 0;
        rst_n = 0;
        #1;
        chk_all_zero(abort == 1 ? "rst_w1" : "rst_r");
        clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_rel_req_ready", 512'(req_ready), 512'd1);
        chk("rst_rel_rsp_valid", 512'(rsp_valid), 512'd0);
        return;
      end
      hs_req = req_valid && req_ready;
      axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      hs_aw = axi_awvalid && axi_awready;
      axi_wready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      hs_w = axi_wvalid && axi_wready;
      cur_wd = axi_wdata; cur_ws = axi_wstrb;
      if (b_pend && b_cnt == 0 && fault != 4 && !axi_bvalid) begin
        if (b_wait > 0) b_wait--;
        else axi_bvalid = 1;
      end
      axi_bid = (fault == 6) ? id ^ 6'd1 : id;
      axi_bresp = (fault == 1) ? 2'b10 : 2'b00;
      hs_b = axi_bvalid && axi_bready;
      axi_arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      hs_ar = axi_arvalid && axi_arready;
      if (ar_cnt == 1 && r_cnt < r_left && !axi_rvalid) begin
        if (r_gap > 0) r_gap--;
        else axi_rvalid = 1;
      end
      axi_rdata = (r_cnt == 1) ? slv_rd(la)[511:256] : slv_rd(la)[255:0];
      axi_rlast = (r_cnt == 1) || (fault == 3);
      axi_rid = (fault == 2 && r_cnt == 1) ? id ^ 6'd1 : id;
      axi_rresp = (fault == 7 && r_cnt == 0) ? 2'b10 : 2'b00;
      hs_r = axi_rvalid && axi_rready;
      rsp_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      hs_rsp = rsp_valid && rsp_ready;
      @(posedge clk);
      #1;
      k++;
    end
    chk("txn_bound", 512'(done), 512'd1);
    clear_inputs();
    act = 0; in_flight = 0;
  endtask

  localparam logic [63:0] A0 = 64'h1000_0040;

  initial begin
    int lat, blat;
    logic [511:0] full_line, part_line;
    full_line = {{32{8'h5A}}, {32{8'hA5}}};
    part_line = {{32{8'h5A}}, {16{8'h3C}}, {16{8'hA5}}};
    clear_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("idle_req_ready", 512'(req_ready), 512'd1);

    run_txn(1, A0, 6'd5, full_line, '1, 0, -1, 0, 0, lat, blat);
    chk("wr_latency", 512'(lat), 512'd5);
    chk("model_pin_full", ref_rd(A0), full_line);
    run_txn(0, A0, 6'd9, '0, '0, 0, -1, 0, 0, lat, blat);
    chk("rd_latency", 512'(lat), 512'd4);
    run_txn(0, A0 + 64'h11, 6'd9, '0, '0, 0, 3, 0, 0, lat, blat);

    run_txn(1, A0, 6'd7, {64{8'h3C}}, 64'h0000_0000_FFFF_0000,
            0, -1, 0, 0, lat, blat);
    chk("model_pin_part", ref_rd(A0), part_line);
    run_txn(0, A0, 6'd8, '0, '0, 0, -1, 0, 0, lat, blat);

    run_txn(1, A0 + 64'h40, 6'd3, rnd512(), '1, 0, -1, 1, 0, lat, blat);
    run_txn(1, A0 + 64'h40, 6'd3, rnd512(), '1, 0, -1, 6, 0, lat, blat);
    run_txn(0, A0, 6'd10, '0, '0, 0, -1, 2, 0, lat, blat);
    run_txn(0, A0, 6'd11, '0, '0, 0, -1, 3, 0, lat, blat);
    run_txn(0, A0, 6'd12, '0, '0, 1, -1, 7, 0, lat, blat);

    run_txn(1, A0 + 64'h80, 6'd4, rnd512(), '1, 0, -1, 4, 0, lat, blat);
    chk("timeout_b_latency", 512'(blat), 512'd16);
    run_txn(0, A0, 6'd13, '0, '0, 0, -1, 0, 0, lat, blat);
    chk("after_timeout_lat", 512'(lat), 512'd4);
    run_txn(0, A0, 6'd14, '0, '0, 0, -1, 5, 0, lat, blat);

    run_txn(1, 64'h2000_0000, 6'd1, rnd512(), '1, 0, -1, 0, 1, lat, blat);
    run_txn(0, A0, 6'd2, '0, '0, 0, 3, 0, 2, lat, blat);
    run_txn(0, A0, 6'd6, '0, '0, 0, -1, 0, 0, lat, blat);

    for (int n = 0; n < 40; n++) begin
      bit wr;
      int f;
      logic [63:0] a;
      logic [63:0] s;
      wr = 1'($urandom_range(0, 1));
      a = 64'h1000_0000 + (64'($urandom_range(0, 7)) << 6) +
          64'($urandom_range(0, 63));
      s = ($urandom_range(0, 3) == 0) ? '1 : {$urandom, $urandom};
      f = 0;
      if ($urandom_range(0, 9) == 0) begin
        if (wr) f = ($urandom_range(0, 1) == 0) ? 1 : 6;
        else    f = ($urandom_range(0, 1) == 0) ? 2 :
                    ($urandom_range(0, 1) == 0) ? 3 : 7;
      end
      run_txn(wr, a, 6'($urandom), rnd512(), s, 1, -1, f, 0,
              lat, blat);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/hawk_axi_line_master.md
Name: hawk_axi_line_master

Overview:
- Synthesizable AXI4 initiator that turns single 64B cacheline read/write requests from the HACD core into 2-beat AXI4 INCR bursts on the memory-controller AXI write/read buses.
- Sits between the Hawk page/list managers and the MC AXI slave, which is either DRAM or the simulation memory model.
- One transaction outstanding at a time. Collects B/R responses, checks protocol (rlast position, ID, resp) and runs a completion watchdog.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles waited in B or R state before the transaction is forced complete with err=1.
- ID_W, 6, AXI ID width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid / req_ready  in/out  1  request handshake
- req_wr  in  1  1=write, 0=read
- req_addr  in  64  line address; bits[5:0] ignored and forced 0 on AXI
- req_id  in  ID_W  AXI ID to use
- req_wdata  in  512  write line; [255:0] is beat0
- req_wstrb  in  64  byte enables; [31:0] is beat0
- rsp_valid / rsp_ready  out/in  1  completion handshake
- rsp_wr  out  1  echo of req_wr
- rsp_id  out  ID_W  echo of req_id
- rsp_rdata  out  512  read line; 0 for writes
- rsp_err  out  1  any xRESP!=0, ID mismatch, rlast error or timeout
- axi_awid/awaddr/awlen/awsize/awburst  out  ID_W/64/8/3/2  len=1, size=5, burst=INCR(01)
- axi_awvalid / axi_awready  out/in  1
- axi_wdata/wstrb/wlast  out  256/32/1
- axi_wvalid / axi_wready  out/in  1
- axi_bid/bresp  in  ID_W/2;  axi_bvalid / axi_bready  in/out  1
- axi_arid/araddr/arlen/arsize/arburst  out  ID_W/64/8/3/2  same constants as AW
- axi_arvalid / axi_arready  out/in  1
- axi_rid/rdata/rresp/rlast  in  ID_W/256/2/1;  axi_rvalid / axi_rready  in/out  1

Behaviour:
- Reset (async assert, sync release): state=IDLE. All valid outputs 0, bready/rready 0, req_ready 0, rsp_* 0, AXI payload outputs 0, watchdog 0.
- A reset mid-transaction abandons the transaction; no response is generated.
- States:
  - IDLE: req_ready=1. Transfer on req_valid&req_ready latches the request into internal registers. Go to AW if req_wr, else AR. Back-to-back: req_ready stays 0 from acceptance until the rsp handshake completes.
  - AW: awvalid=1, payload held stable until awready. Go to W0 on handshake.
  - W0: starts the cycle after the AW handshake; W never precedes or accompanies AW. Drive wvalid=1, wdata=line[255:0], wstrb=strb[31:0], wlast=0. Go to W1 on wready.
  - W1: wvalid=1, upper halves, wlast=1. Go to B on wready.
  - B: bready=1, watchdog counts. On bvalid: err |= (bresp!=0) | (bid!=latched id); go to RSP.
  - AR: arvalid=1 until arready; go to R.
  - R: rready=1, beat counter 0..1, watchdog counts.
    - Beat0 -> rdata[255:0]; err if rlast=1.
    - Beat1 -> rdata[511:256]; err if rlast=0.
    - Every beat: err |= (rresp!=0) | (rid!=id).
    - Go to RSP after beat1.
  - RSP: rsp_valid=1 with stable payload until rsp_ready; then go to IDLE.
- Watchdog:
  - Cleared on entry to B/R. Reaching TIMEOUT_CYCLES-1 forces err=1, deasserts bready/rready, and goes to RSP; unreceived read halves stay 0.
  - Late responses after a timeout are dropped: bready/rready are 0 outside B/R.
- rsp_valid is registered: 1 cycle after the final B/R beat handshake.
- Minimum latency, zero-wait slave: write req accept -> rsp_valid in 5 cycles; read in 4 cycles.
- err clears on each new request accept.
- Extra R beats beyond 2 are not expected. They are not consumed (rready=0 in RSP/IDLE).

Test Plan:
- Write addr 0x1000_0040, id 5, wdata beat0=0xA5.., beat1=0x5A.., wstrb all ones -> AW awaddr=0x1000_0040, awlen=1, awsize=5. W beats in order, wlast on beat 2 only. rsp_valid with rsp_id=5, err=0.
- Read same address with id 9 -> rsp_rdata = {0x5A..,0xA5..}, err=0. Stall rready-driven slave 3 cycles between beats -> same data, no beat lost.
- Partial write with wstrb=64'h0000_0000_FFFF_0000 -> beat0 wstrb=32'hFFFF_0000, beat1 wstrb=0. Read back shows only bytes 16-31 changed.
- Error injection: bresp=2'b10 -> rsp_err=1. rid=id^1 on beat1 -> rsp_err=1. rlast on beat0 -> rsp_err=1.
- Slave never returns B, TIMEOUT_CYCLES=16 -> rsp_valid 16 cycles after B entry, err=1. Next request is accepted normally.
- rst_n pulsed low during W1 and during R -> all outputs 0 immediately (async). After release, IDLE with req_ready=1 and no rsp_valid.
